// File: rtl/rom_read_cache.sv
// rom_read_cache: direct-mapped 64-bit read cache between the ROM port and the ddram read channel
module rom_read_cache #(
    parameter int ADDR_W  = 22,
    parameter int INDEX_W = 8
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              flush,
    output logic              busy,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_req,
    output logic              cpu_ack,
    output logic [63:0]       cpu_data,
    output logic [ADDR_W+2:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [63:0]       mem_data
);
    localparam int LINES = 2 ** INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W;

    typedef enum logic [1:0] {S_FLUSH, S_IDLE, S_LOOKUP, S_MISS} state_t;

    state_t              state_q, state_d;
    logic [INDEX_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic                mem_req_q, mem_req_d;
    logic                abort_q, abort_d;
    logic [63:0]         cpu_data_q, cpu_data_d;
    logic [ADDR_W+2:0]   mem_addr_q, mem_addr_d;

    logic [63:0]         data_ram [LINES];
    logic [TAG_W:0]      tag_ram  [LINES];
    logic [63:0]         rd_data_q;
    logic [TAG_W:0]      rd_tag_q;
    logic                tag_we, data_we, drop;
    logic [INDEX_W-1:0]  w_idx;
    logic [TAG_W:0]      w_tag;
    logic                pending, mem_done, hit;

    assign pending  = cpu_req != cpu_ack_q;
    assign mem_done = mem_ack == mem_req_q;
    assign hit      = rd_tag_q[TAG_W] && rd_tag_q[TAG_W-1:0] == addr_q[ADDR_W-1:INDEX_W];
    assign drop     = abort_q || flush;
    assign busy     = state_q == S_FLUSH;
    assign cpu_ack  = cpu_ack_q;
    assign cpu_data = cpu_data_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

    // Tag entries are {valid, tag}; the read always follows cpu_addr so LOOKUP sees the line latched in IDLE
    always_ff @(posedge clk_sys) begin
        rd_data_q <= data_ram[cpu_addr[INDEX_W-1:0]];
        rd_tag_q  <= tag_ram[cpu_addr[INDEX_W-1:0]];
        if (tag_we) tag_ram[w_idx] <= w_tag;
        if (data_we) data_ram[w_idx] <= mem_data;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        cpu_ack_d  = cpu_ack_q;
        mem_req_d  = mem_req_q;
        abort_d    = abort_q;
        cpu_data_d = cpu_data_q;
        mem_addr_d = mem_addr_q;
        tag_we     = 1'b0;
        data_we    = 1'b0;
        w_idx      = addr_q[INDEX_W-1:0];
        w_tag      = {1'b1, addr_q[ADDR_W-1:INDEX_W]};
        case (state_q)
            S_FLUSH: begin
                tag_we = 1'b1;
                w_idx  = cnt_q;
                w_tag  = '0;
                cnt_d  = flush ? '0 : cnt_q + 1'b1;
                if (!flush && &cnt_q) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (flush) begin
                    state_d = S_FLUSH;
                    cnt_d   = '0;
                end else if (pending) begin
                    addr_d  = cpu_addr;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (flush) begin
                    state_d = S_FLUSH;
                    cnt_d   = '0;
                end else if (hit) begin
                    cpu_data_d = rd_data_q;
                    cpu_ack_d  = ~cpu_ack_q;
                    state_d    = S_IDLE;
                end else begin
                    mem_addr_d = {addr_q, 3'b000};
                    mem_req_d  = ~mem_req_q;
                    state_d    = S_MISS;
                end
            end
            S_MISS: begin
                // A flush seen at any point of the fetch still acks the CPU but skips the install
                if (mem_done) begin
                    data_we    = !drop;
                    tag_we     = !drop;
                    cpu_data_d = mem_data;
                    cpu_ack_d  = ~cpu_ack_q;
                    abort_d    = 1'b0;
                    state_d    = drop ? S_FLUSH : S_IDLE;
                    cnt_d      = '0;
                end else begin
                    abort_d = drop;
                end
            end
            default: state_d = S_FLUSH;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= S_FLUSH;
            cnt_q      <= '0;
            addr_q     <= '0;
            cpu_ack_q  <= 1'b0;
            mem_req_q  <= 1'b0;
            abort_q    <= 1'b0;
            cpu_data_q <= '0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            cpu_ack_q  <= cpu_ack_d;
            mem_req_q  <= mem_req_d;
            abort_q    <= abort_d;
            cpu_data_q <= cpu_data_d;
            mem_addr_q <= mem_addr_d;
        end
    end
endmodule

// File: tb/tb_rom_read_cache.sv
// tb_rom_read_cache: scoreboard bench with a toggle-handshake ddram model for rom_read_cache
module tb_rom_read_cache;
    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        busy;
    logic [21:0] cpu_addr = '0;
    logic        cpu_req = 1'b0;
    logic        cpu_ack;
    logic [63:0] cpu_data;
    logic [24:0] mem_addr;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [63:0] mem_data = '0;

    int checks = 0, errors = 0;
    int mem_delay = 0, mem_wait = 0, n_mem = 0;
    logic mem_req_prev = 1'b0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic [21:0] addr;
        bit          miss;
    } vec_t;
    vec_t tbl[8];

    rom_read_cache #(.ADDR_W(22), .INDEX_W(8)) dut (
        .clk_sys(clk_sys), .reset(reset), .flush(flush), .busy(busy),
        .cpu_addr(cpu_addr), .cpu_req(cpu_req), .cpu_ack(cpu_ack), .cpu_data(cpu_data),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_data(mem_data)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [63:0] word_of(input logic [21:0] a);
        return a == 22'h123 ? 64'hDEADBEEF_01234567 : {a ^ 22'h2AAAAA, 20'hA5A5A, a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ddram model: answers each mem_req toggle after mem_delay extra cycles
    initial forever begin
        @(posedge clk_sys);
        #1;
        if (reset) begin
            mem_ack = 1'b0;
            mem_wait = 0;
            mem_req_prev = 1'b0;
        end else begin
            if (mem_req !== mem_req_prev) begin
                n_mem++;
                mem_req_prev = mem_req;
            end
            if (mem_req !== mem_ack) begin
                if (mem_wait >= mem_delay) begin
                    mem_data = word_of(mem_addr[24:3]);
                    mem_ack = mem_req;
                    mem_wait = 0;
                end else mem_wait++;
            end
        end
    end

    task automatic step();
        @(posedge clk_sys);
        #2;
    endtask

    task automatic start_req(input logic [21:0] a);
        exp_q.push_back(word_of(a));
        cpu_addr = a;
        cpu_req = ~cpu_req;
    endtask

    task automatic wait_ack(input string name, output int lat);
        lat = 0;
        while (cpu_ack !== cpu_req && lat < 3000) begin
            step();
            lat++;
        end
        check({name, "_ack"}, 64'(cpu_ack), 64'(cpu_req));
        if (exp_q.size() > 0) check({name, "_data"}, cpu_data, exp_q.pop_front());
    endtask

    task automatic do_read(input logic [21:0] a, input bit miss, input string name);
        int lat, m0;
        m0 = n_mem;
        start_req(a);
        wait_ack(name, lat);
        check({name, "_miss"}, 64'(n_mem - m0), 64'(miss));
        if (!miss) check({name, "_lat"}, 64'(lat), 64'd2);
    endtask

    initial begin
        int n, lat, m0, acks;
        tbl[0] = '{22'h000123, 1'b0};
        tbl[1] = '{22'h000010, 1'b1};
        tbl[2] = '{22'h000110, 1'b1};
        tbl[3] = '{22'h000010, 1'b1};
        tbl[4] = '{22'h000010, 1'b0};
        tbl[5] = '{22'h000110, 1'b1};
        tbl[6] = '{22'h3FFFFF, 1'b1};
        tbl[7] = '{22'h3FFFFF, 1'b0};
        repeat (3) step();
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_cpu_ack", 64'(cpu_ack), 64'd0);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_cpu_data", cpu_data, 64'd0);
        reset = 1'b0;
        m0 = n_mem;
        n = 0;
        while (busy && n < 400) begin
            if (n == 10) start_req(22'h000123);
            n++;
            step();
        end
        check("busy_len", 64'(n), 64'd256);
        check("held_during_walk", 64'(cpu_ack), 64'd0);
        wait_ack("cold", lat);
        check("cold_miss", 64'(n_mem - m0), 64'd1);
        check("cold_mem_addr", 64'(mem_addr), 64'h918);
        foreach (tbl[i]) do_read(tbl[i].addr, tbl[i].miss, $sformatf("vec%0d", i));
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        n = 0;
        while (busy && n < 400) begin
            n++;
            step();
        end
        check("flush_len", 64'(n), 64'd256);
        do_read(22'h000123, 1'b1, "post_flush");
        mem_delay = 20;
        m0 = n_mem;
        start_req(22'h000200);
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_ack("flush_miss", lat);
        mem_delay = 0;
        check("flush_miss_count", 64'(n_mem - m0), 64'd1);
        check("busy_after_miss", 64'(busy), 64'd1);
        do_read(22'h000200, 1'b1, "not_installed");
        flush = 1'b1;
        step();
        m0 = n_mem;
        start_req(22'h000123);
        acks = 0;
        repeat (1000) begin
            step();
            if (cpu_ack === cpu_req) acks++;
        end
        check("held_1000", 64'(acks), 64'd0);
        flush = 1'b0;
        wait_ack("after_hold", lat);
        check("hold_lat", 64'(lat), 64'd259);
        check("hold_miss", 64'(n_mem - m0), 64'd1);
        step();
        check("cpu_parity", 64'(cpu_ack), 64'(cpu_req));
        check("mem_parity", 64'(mem_ack), 64'(mem_req));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end
endmodule
